// File: rtl/ddr_pkg.sv
// Shared types and defaults for the port-A DDR request controller.
package ddr_pkg;

  localparam int DDR_ADDR_W  = 19;
  localparam int DDR_DATA_W  = 8;
  localparam int DDR_TIMEOUT = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } ddr_req_state_t;

  // Saturating +1 for the 32-bit statistics counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ddr_req_stats.sv
// Saturating activity counters for ddr_req_ctrl, built only with DDR_REQ_STATS_EN.
module ddr_req_stats
  import ddr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        evRead_i,
  input  logic        evWrite_i,
  input  logic        evWait_i,
  input  logic        evHit_i,
  input  logic        evTimeout_i,
  output logic [31:0] stat_rd_o,
  output logic [31:0] stat_wr_o,
  output logic [31:0] stat_wait_o,
  output logic [15:0] stat_hit_o,
  output logic [15:0] stat_to_o
);

  logic [31:0] statRd_q, statWr_q, statWait_q;
  logic [15:0] statHit_q, statTo_q;

  // Each counter sticks at its maximum instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      statRd_q   <= '0;
      statWr_q   <= '0;
      statWait_q <= '0;
      statHit_q  <= '0;
      statTo_q   <= '0;
    end else begin
      if (evRead_i)    statRd_q   <= sat_inc32(statRd_q);
      if (evWrite_i)   statWr_q   <= sat_inc32(statWr_q);
      if (evWait_i)    statWait_q <= sat_inc32(statWait_q);
      if (evHit_i)     statHit_q  <= sat_inc16(statHit_q);
      if (evTimeout_i) statTo_q   <= sat_inc16(statTo_q);
    end
  end

  assign stat_rd_o   = statRd_q;
  assign stat_wr_o   = statWr_q;
  assign stat_wait_o = statWait_q;
  assign stat_hit_o  = statHit_q;
  assign stat_to_o   = statTo_q;

endmodule

// File: rtl/ddr_req_ctrl.sv
// Initiator-side controller for DDR port A: one byte request at a time, last-address bypass, timeout.
// Optional statistics counters are enabled with the DDR_REQ_STATS_EN macro.
module ddr_req_ctrl
  import ddr_pkg::*;
#(
  parameter int ADDR_W  = DDR_ADDR_W,
  parameter int DATA_W  = DDR_DATA_W,
  parameter int TIMEOUT = DDR_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              mem_d_ready_we,
  input  logic              mem_d_ready_re
`ifdef DDR_REQ_STATS_EN
  ,
  output logic [31:0]       stat_rd,
  output logic [31:0]       stat_wr,
  output logic [31:0]       stat_wait,
  output logic [15:0]       stat_hit,
  output logic [15:0]       stat_to
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  ddr_req_state_t    state_q, state_d;
  logic              reqWe_q, reqWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memData_q, memData_d;
  logic              memWe_q, memWe_d;
  logic              reqReady_q, reqReady_d;
  logic              rspValid_q, rspValid_d;
  logic [DATA_W-1:0] rspRdata_q, rspRdata_d;
  logic              rspErr_q, rspErr_d;
  logic              cacheValid_q, cacheValid_d;
  logic [ADDR_W-1:0] lastAddr_q, lastAddr_d;
  logic [DATA_W-1:0] cacheData_q, cacheData_d;
  logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;

  logic bypassHit;
  logic memDone;
  logic waitExpired;

  assign bypassHit   = !req_we && cacheValid_q && (req_addr == lastAddr_q);
  assign memDone     = reqWe_q ? mem_d_ready_we : mem_d_ready_re;
  assign waitExpired = (waitCnt_q == CNT_LAST);

  // Next-state logic; mem_addr/mem_data only move when a new access is issued.
  always_comb begin
    state_d      = state_q;
    reqWe_d      = reqWe_q;
    memAddr_d    = memAddr_q;
    memData_d    = memData_q;
    memWe_d      = 1'b0;
    reqReady_d   = reqReady_q;
    rspValid_d   = 1'b0;
    rspRdata_d   = rspRdata_q;
    rspErr_d     = rspErr_q;
    cacheValid_d = cacheValid_q;
    lastAddr_d   = lastAddr_q;
    cacheData_d  = cacheData_q;
    waitCnt_d    = waitCnt_q;

    unique case (state_q)
      IDLE: begin
        reqReady_d = 1'b1;
        if (req_valid) begin
          reqReady_d = 1'b0;
          reqWe_d    = req_we;
          if (bypassHit) begin
            state_d    = RESP;
            rspValid_d = 1'b1;
            rspRdata_d = cacheData_q;
            rspErr_d   = 1'b0;
          end else begin
            state_d   = ISSUE;
            memAddr_d = req_addr;
            memData_d = req_wdata;
            memWe_d   = req_we;
          end
        end
      end

      ISSUE: begin
        state_d   = WAIT;
        waitCnt_d = '0;
      end

      WAIT: begin
        // A completion on the timeout edge still counts as success.
        if (memDone) begin
          state_d      = RESP;
          rspValid_d   = 1'b1;
          rspErr_d     = 1'b0;
          cacheValid_d = 1'b1;
          lastAddr_d   = memAddr_q;
          if (reqWe_q) begin
            cacheData_d = memData_q;
          end else begin
            cacheData_d = mem_q;
            rspRdata_d  = mem_q;
          end
        end else if (waitExpired) begin
          state_d      = RESP;
          rspValid_d   = 1'b1;
          rspErr_d     = 1'b1;
          cacheValid_d = 1'b0;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end

      RESP: begin
        state_d    = IDLE;
        rspErr_d   = 1'b0;
        reqReady_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      reqWe_q      <= 1'b0;
      memAddr_q    <= '0;
      memData_q    <= '0;
      memWe_q      <= 1'b0;
      reqReady_q   <= 1'b1;
      rspValid_q   <= 1'b0;
      rspRdata_q   <= '0;
      rspErr_q     <= 1'b0;
      cacheValid_q <= 1'b0;
      lastAddr_q   <= '0;
      cacheData_q  <= '0;
      waitCnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      reqWe_q      <= reqWe_d;
      memAddr_q    <= memAddr_d;
      memData_q    <= memData_d;
      memWe_q      <= memWe_d;
      reqReady_q   <= reqReady_d;
      rspValid_q   <= rspValid_d;
      rspRdata_q   <= rspRdata_d;
      rspErr_q     <= rspErr_d;
      cacheValid_q <= cacheValid_d;
      lastAddr_q   <= lastAddr_d;
      cacheData_q  <= cacheData_d;
      waitCnt_q    <= waitCnt_d;
    end
  end

  assign req_ready = reqReady_q;
  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspRdata_q;
  assign rsp_err   = rspErr_q;
  assign mem_addr  = memAddr_q;
  assign mem_data  = memData_q;
  assign mem_we    = memWe_q;

`ifdef DDR_REQ_STATS_EN
  logic inWait;
  assign inWait = (state_q == WAIT);

  ddr_req_stats u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .evRead_i    (inWait && memDone && !reqWe_q),
    .evWrite_i   (inWait && memDone && reqWe_q),
    .evWait_i    (inWait),
    .evHit_i     ((state_q == IDLE) && req_valid && bypassHit),
    .evTimeout_i (inWait && !memDone && waitExpired),
    .stat_rd_o   (stat_rd),
    .stat_wr_o   (stat_wr),
    .stat_wait_o (stat_wait),
    .stat_hit_o  (stat_hit),
    .stat_to_o   (stat_to)
  );
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ddr_req_ctrl.sv
// Scoreboard bench for ddr_req_ctrl: directed requests push expected responses, a monitor pops and compares.
module tb_ddr_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [18:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [18:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic [7:0]  mem_q;
  logic        mem_d_ready_we;
  logic        mem_d_ready_re;
`ifdef DDR_REQ_STATS_EN
  logic [31:0] stat_rd, stat_wr, stat_wait;
  logic [15:0] stat_hit, stat_to;
`endif

  typedef struct packed {
    logic       isRead;
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  rsp_t expQ[$];
  rsp_t monE;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ddr_req_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_we         (mem_we),
    .mem_q          (mem_q),
    .mem_d_ready_we (mem_d_ready_we),
    .mem_d_ready_re (mem_d_ready_re)
`ifdef DDR_REQ_STATS_EN
    ,
    .stat_rd        (stat_rd),
    .stat_wr        (stat_wr),
    .stat_wait      (stat_wait),
    .stat_hit       (stat_hit),
    .stat_to        (stat_to)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, monE.err});
        if (monE.isRead && !monE.err)
          checkOutput("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, monE.rdata});
      end
    end
  end

  // One request; delay = cycles after the issue cycle in which the matching strobe is pulsed.
  task automatic applyStimulus(input logic we, input logic [18:0] addr, input logic [7:0] wdata,
                               input int delay, input bit expHit, input logic [7:0] expRdata,
                               input bit expTimeout, input bit wrongPulse);
    int guard = 0;
    logic [18:0] prevAddr;
    while (!req_ready && guard < 100) begin
      step();
      guard++;
    end
    if (!req_ready) begin
      checkOutput("ready_wait_timeout", 32'd0, 32'd1);
      return;
    end
    prevAddr = mem_addr;
    expQ.push_back('{isRead: !we, rdata: expRdata, err: expTimeout});
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    req_valid = 1'b0;
    req_we    = 1'b0;
    checkOutput("accept_ready_low", {31'd0, req_ready}, 32'd0);
    if (expHit) begin
      checkOutput("hit_rsp_cycle1", {31'd0, rsp_valid}, 32'd1);
      checkOutput("hit_no_mem_we", {31'd0, mem_we}, 32'd0);
      checkOutput("hit_addr_unchanged", {13'd0, mem_addr}, {13'd0, prevAddr});
      step();
      checkOutput("hit_rsp_done", {31'd0, rsp_valid}, 32'd0);
      checkOutput("hit_ready_back", {31'd0, req_ready}, 32'd1);
      return;
    end
    checkOutput("issue_no_rsp", {31'd0, rsp_valid}, 32'd0);
    checkOutput("issue_mem_we", {31'd0, mem_we}, {31'd0, we});
    checkOutput("issue_mem_addr", {13'd0, mem_addr}, {13'd0, addr});
    if (we) checkOutput("issue_mem_data", {24'd0, mem_data}, {24'd0, wdata});
    step();
    checkOutput("wait_mem_we_low", {31'd0, mem_we}, 32'd0);
    if (expTimeout) begin
      repeat (31) step();
      checkOutput("timeout_not_early", {31'd0, rsp_valid}, 32'd0);
      step();
      checkOutput("timeout_rsp_cycle34", {31'd0, rsp_valid}, 32'd1);
    end else begin
      for (int c = 2; c <= 1 + delay; c++) begin
        if (wrongPulse && c == 2) begin
          if (we) mem_d_ready_re = 1'b1;
          else    mem_d_ready_we = 1'b1;
        end
        if (c == 1 + delay) begin
          if (we) mem_d_ready_we = 1'b1;
          else begin
            mem_d_ready_re = 1'b1;
            mem_q          = expRdata;
          end
        end
        step();
        mem_d_ready_we = 1'b0;
        mem_d_ready_re = 1'b0;
        mem_q          = 8'hEE;
        if (c < 1 + delay) checkOutput("wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      checkOutput("rsp_cycle", {31'd0, rsp_valid}, 32'd1);
      checkOutput("mem_addr_held", {13'd0, mem_addr}, {13'd0, addr});
    end
    step();
    checkOutput("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    checkOutput("ready_after_rsp", {31'd0, req_ready}, 32'd1);
    checkOutput("mem_addr_between", {13'd0, mem_addr}, {13'd0, addr});
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    checkOutput({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    checkOutput({tag, "_rsp_rdata"}, {24'd0, rsp_rdata}, 32'd0);
    checkOutput({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    checkOutput({tag, "_mem_addr"}, {13'd0, mem_addr}, 32'd0);
    checkOutput({tag, "_mem_data"}, {24'd0, mem_data}, 32'd0);
    checkOutput({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    req_valid      = 1'b0;
    req_we         = 1'b0;
    req_addr       = '0;
    req_wdata      = '0;
    mem_q          = 8'hEE;
    mem_d_ready_we = 1'b0;
    mem_d_ready_re = 1'b0;
    #22;
    checkResetValues("por");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    applyStimulus(1'b1, 19'h00100, 8'hA5, 8, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 19'h00100, 8'h00, 0, 1'b1, 8'hA5, 1'b0, 1'b0);
    applyStimulus(1'b0, 19'h00101, 8'h00, 1, 1'b0, 8'h3C, 1'b0, 1'b0);
    applyStimulus(1'b0, 19'h00102, 8'h00, 1, 1'b0, 8'h33, 1'b0, 1'b0);
    applyStimulus(1'b1, 19'h00102, 8'h5A, 0, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 19'h00102, 8'h00, 2, 1'b0, 8'h33, 1'b0, 1'b0);
    applyStimulus(1'b1, 19'h00150, 8'h77, 4, 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 19'h00150, 8'h00, 0, 1'b1, 8'h77, 1'b0, 1'b0);
    applyStimulus(1'b1, 19'h00150, 8'h78, 2, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 19'h00150, 8'h00, 0, 1'b1, 8'h78, 1'b0, 1'b0);

    // Abort a write while it sits in WAIT; no response may follow.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 19'h00300;
    req_wdata = 8'h11;
    step();
    req_valid = 1'b0;
    req_we    = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("midrst");
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checkResetValues("postrst");

    applyStimulus(1'b0, 19'h00150, 8'h00, 1, 1'b0, 8'h78, 1'b0, 1'b0);

    repeat (3) step();
    checkOutput("queue_empty", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr_req_ctrl.md
Name: ddr_req_ctrl

Overview:
- Initiator-side controller for the single-port DDR model/interface (port A).
- Accepts one byte read/write request at a time from the processor datapath and drives mem_addr/mem_data/mem_we.
- Waits for the responder's d_ready_we / d_ready_re pulse, then returns read data or a write acknowledge to the requester.
- Holds the address stable between transactions, serves repeat reads of the last address locally, and times out hung accesses.

Parameters:
ADDR_W, 19, memory byte address width
DATA_W, 8, data width
TIMEOUT, 32, maximum WAIT cycles before error completion (≥2)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
req_ready  out  1  controller can accept a request
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_W  read data, valid with rsp_valid on reads
rsp_err  out  1  timeout flag, valid with rsp_valid
mem_addr  out  ADDR_W  to DDR addr_a
mem_data  out  DATA_W  to DDR data_a
mem_we  out  1  to DDR we_a
mem_q  in  DATA_W  from DDR q_a
mem_d_ready_we  in  1  write-complete pulse
mem_d_ready_re  in  1  read-data-ready pulse

Behaviour:
- Reset values:
  - All outputs 0 except req_ready = 1.
  - State IDLE; cache_valid = 0; last_addr = 0; wait counter = 0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid at an edge, latch we/addr/wdata and drop req_ready.
  - Bypass hit: read (req_we = 0) with cache_valid = 1 and req_addr == last_addr.
    - Go to RESP with rsp_rdata = cached byte.
    - No memory activity; mem_addr is unchanged.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - mem_addr <= addr; mem_data <= wdata; mem_we <= we.
  - Next state WAIT; counter cleared.
- WAIT:
  - mem_we = 0; mem_addr and mem_data are held.
  - Write completes only on mem_d_ready_we; read completes only on mem_d_ready_re. The non-matching pulse is ignored.
  - On read completion, rsp_rdata <= mem_q as sampled at that same edge.
  - Counter increments each WAIT cycle. At TIMEOUT-1 with no completion: rsp_err <= 1, cache_valid <= 0, go to RESP.
  - Completion on the same edge as the timeout wins; rsp_err = 0.
- RESP (1 cycle):
  - rsp_valid = 1, then clear rsp_valid/rsp_err and return to IDLE.
  - req_ready rises in the cycle after rsp_valid.
- Cache update on successful completion:
  - Write: last_addr <= addr, cache byte <= wdata, cache_valid <= 1.
  - Read: last_addr <= addr, cache byte <= mem_q, cache_valid <= 1.
- Latency:
  - Accept at edge 0 → mem_we/mem_addr valid in cycle 1 → WAIT from cycle 2.
  - Ready sampled at edge k → rsp_valid high in cycle k+1.
  - Bypass hit: rsp_valid in cycle 1.
- mem_addr never returns to 0 between transactions. The responder detects accesses by address change, so a spurious change would trigger a false access.
- A write to the same address as the current mem_addr is legal; the responder acknowledges it through the write-enable path.
- Reset mid-transaction aborts immediately to reset values. No rsp_valid is generated.
- req_valid while req_ready = 0 is ignored; the requester must hold the request.

Optional Feature:
- Macro: DDR_REQ_STATS_EN.
- With the macro defined:
  - Extra output ports stat_rd (32), stat_wr (32), stat_wait (32), stat_hit (16), stat_to (16).
  - Counts: completed reads, completed writes, total WAIT cycles, bypass hits, timeouts.
  - Counters saturate and reset to 0.
- Without the macro: these ports and counters do not exist; the core behaviour is identical.

Decomposition:
- Shared package ddr_pkg:
  - DDR_ADDR_W = 19, DDR_DATA_W = 8.
  - State enum ddr_req_state_t {IDLE, ISSUE, WAIT, RESP}.
  - Default TIMEOUT constant.
- One sub-module, ddr_req_stats: holds the saturating counters; instantiated only under DDR_REQ_STATS_EN.

Test Plan:
- Write addr 0x00100, data 0xA5; responder pulses d_ready_we 8 cycles later → mem_we high exactly in cycle 1, rsp_valid one cycle, rsp_err = 0.
- Read addr 0x00100 after writing 0xA5 there → bypass hit, rsp_valid in cycle 1, rsp_rdata = 0xA5, mem_addr unchanged, no mem_we.
- Read 0x00101 then 0x00102 (sequential) with d_ready_re after 1 cycle each → rsp_rdata equals memory contents; mem_addr holds between requests.
- No ready pulse, TIMEOUT = 32 → rsp_valid with rsp_err = 1 at cycle 34 after accept; next read of the same address is not a bypass hit.
- Write waiting while d_ready_re pulses, then d_ready_we 3 cycles later → completion only on d_ready_we.
- rst_n asserted in WAIT → all outputs return to reset values asynchronously, req_ready = 1, no rsp_valid pulse.
